lock_access_controller: RTL and testbench

Access-policy stage downstream of the six-digit lock controller. Consumes the registered password-compare result (`res`) once per verify attempt and drives the physical unlock enable, failed-attempt accounting, timed lockout and optional alarm. Sits between the lock controller's judge output and the actuator/indicator pins; it is the only block allowed to assert `unlock`.

---
 rtl/lock_access_controller.sv | 127 ++++++++++++
 tb/tb_lock_access_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lock_access_controller.sv
// Access-policy stage after the lock controller: unlock window, failure count, timed lockout.
// Optional blinking alarm during lockout when LOCK_ALARM_EN is defined.
module lock_access_controller #(
    parameter int MAX_FAIL    = 3,
    parameter int UNLOCK_CYC  = 16,
    parameter int LOCKOUT_CYC = 64,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       m,
    input  logic       judge_valid,
    input  logic       res,
    input  logic       relock,
    output logic       unlock,
    output logic       locked_out,
    output logic       fail_pulse,
    output logic [2:0] fail_cnt,
    output logic       alarm
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    localparam logic [2:0]       MAX_F     = 3'(MAX_FAIL);
    localparam logic [TMR_W-1:0] UNLOCK_LD = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LD   = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    state_t           state;
    state_t           state_n;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_n;
    logic [2:0]       cnt_n;
    logic             pulse_n;
    logic             verify_ev;
    logic             tmr_zero;

    assign verify_ev = judge_valid & m;
    assign tmr_zero  = (tmr == '0);

    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        cnt_n   = fail_cnt;
        pulse_n = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (verify_ev) begin
                    if (res) begin
                        state_n = S_OPEN;
                        tmr_n   = UNLOCK_LD;
                        cnt_n   = 3'd0;
                    end else begin
                        pulse_n = 1'b1;
                        if (fail_cnt != MAX_F) begin
                            cnt_n = fail_cnt + 3'd1;
                        end
                        if (cnt_n == MAX_F) begin
                            state_n = S_LOCKOUT;
                            tmr_n   = LOCK_LD;
                        end
                    end
                end
            end
            S_OPEN: begin
                // leaving verify mode closes the door just like relock
                if (relock || !m || tmr_zero) begin
                    state_n = S_IDLE;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr - TMR_ONE;
                end
            end
            S_LOCKOUT: begin
                if (tmr_zero) begin
                    state_n = S_IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    tmr_n = tmr - TMR_ONE;
                end
            end
            default: begin
                state_n = S_IDLE;
                tmr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= S_IDLE;
            tmr        <= '0;
            fail_cnt   <= 3'd0;
            fail_pulse <= 1'b0;
            unlock     <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_n;
            tmr        <= tmr_n;
            fail_cnt   <= cnt_n;
            fail_pulse <= pulse_n;
            unlock     <= (state_n == S_OPEN);
            locked_out <= (state_n == S_LOCKOUT);
        end
    end

`ifdef LOCK_ALARM_EN
    // registered from next-state so it equals locked_out & tmr[2]
    logic alarm_n;
    assign alarm_n = (state_n == S_LOCKOUT) & tmr_n[2];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            alarm <= 1'b0;
        end else begin
            alarm <= alarm_n;
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_lock_access_controller.sv
// Directed bench for lock_access_controller (MAX_FAIL=3, UNLOCK_CYC=4, LOCKOUT_CYC=8).
// Alarm expectations follow LOCK_ALARM_EN.
module tb_lock_access_controller;

    logic       clk = 1'b0;
    logic       clr;
    logic       m;
    logic       judge_valid;
    logic       res;
    logic       relock;
    logic       unlock;
    logic       locked_out;
    logic       fail_pulse;
    logic [2:0] fail_cnt;
    logic       alarm;

    int n_chk  = 0;
    int n_pass = 0;

    lock_access_controller #(
        .MAX_FAIL   (3),
        .UNLOCK_CYC (4),
        .LOCKOUT_CYC(8),
        .TMR_W      (8)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .m          (m),
        .judge_valid(judge_valid),
        .res        (res),
        .relock     (relock),
        .unlock     (unlock),
        .locked_out (locked_out),
        .fail_pulse (fail_pulse),
        .fail_cnt   (fail_cnt),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic r);
        judge_valid = 1'b1;
        res         = r;
        step();
        judge_valid = 1'b0;
    endtask

    function automatic int alarm_exp(input int k);
`ifdef LOCK_ALARM_EN
        return (((7 - k) >> 2) & 1);
`else
        return 0;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_u"}, int'(unlock), 0);
        chk({tag, "_lo"}, int'(locked_out), 0);
        chk({tag, "_fp"}, int'(fail_pulse), 0);
        chk({tag, "_fc"}, int'(fail_cnt), 0);
        chk({tag, "_al"}, int'(alarm), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clr         = 1'b0;
        m           = 1'b1;
        judge_valid = 1'b0;
        res         = 1'b0;
        relock      = 1'b0;
        step();
        step();
        chk_all_zero("rst");
        clr = 1'b1;
        step();

        // success: four cycles open
        strobe(1'b1);
        chk("ok_fc", int'(fail_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            chk("ok_open", int'(unlock), 1);
            step();
        end
        chk("ok_close", int'(unlock), 0);

        // three back-to-back fails -> lockout
        strobe(1'b0);
        chk("f1_fp", int'(fail_pulse), 1);
        chk("f1_fc", int'(fail_cnt), 1);
        chk("f1_lo", int'(locked_out), 0);
        strobe(1'b0);
        chk("f2_fp", int'(fail_pulse), 1);
        chk("f2_fc", int'(fail_cnt), 2);
        strobe(1'b0);
        chk("f3_fp", int'(fail_pulse), 1);
        chk("f3_fc", int'(fail_cnt), 3);
        for (int i = 0; i < 8; i++) begin
            chk("lo_on", int'(locked_out), 1);
            chk("lo_alarm", int'(alarm), alarm_exp(i));
            if (i > 0) chk("lo_fp", int'(fail_pulse), 0);
            step();
        end
        chk("lo_off", int'(locked_out), 0);
        chk("lo_fc0", int'(fail_cnt), 0);
        chk("lo_al0", int'(alarm), 0);

        // two fails then success clears count
        strobe(1'b0);
        step();
        chk("ff_fp0", int'(fail_pulse), 0);
        strobe(1'b0);
        chk("ffs_fc2", int'(fail_cnt), 2);
        strobe(1'b1);
        chk("ffs_fc0", int'(fail_cnt), 0);
        chk("ffs_u", int'(unlock), 1);
        chk("ffs_lo", int'(locked_out), 0);
        repeat (4) step();
        chk("ffs_end", int'(unlock), 0);

        // strobes, relock and m ignored during lockout
        strobe(1'b0);
        strobe(1'b0);
        strobe(1'b0);
        judge_valid = 1'b1;
        res         = 1'b1;
        relock      = 1'b1;
        m           = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) m = 1'b1;
            chk("lig_lo", int'(locked_out), 1);
            chk("lig_u", int'(unlock), 0);
            step();
        end
        judge_valid = 1'b0;
        relock      = 1'b0;
        chk("lig_end", int'(locked_out), 0);
        chk("lig_u2", int'(unlock), 0);
        chk("lig_fc", int'(fail_cnt), 0);

        // relock in open cycle 2
        strobe(1'b1);
        step();
        chk("rl_pre", int'(unlock), 1);
        relock = 1'b1;
        step();
        chk("rl_drop", int'(unlock), 0);
        relock = 1'b0;

        // m drop in open cycle 2
        strobe(1'b1);
        step();
        m = 1'b0;
        step();
        chk("md_drop", int'(unlock), 0);

        // strobes in set-password mode are ignored
        strobe(1'b0);
        chk("m0_fp", int'(fail_pulse), 0);
        chk("m0_fc", int'(fail_cnt), 0);
        strobe(1'b1);
        chk("m0_u", int'(unlock), 0);
        m = 1'b1;

        // relock coinciding with final open cycle
        strobe(1'b1);
        repeat (3) step();
        chk("rz_last", int'(unlock), 1);
        relock = 1'b1;
        step();
        chk("rz_drop", int'(unlock), 0);
        step();
        chk("rz_stay", int'(unlock), 0);
        relock = 1'b0;

        // async clear mid-lockout
        strobe(1'b0);
        strobe(1'b0);
        strobe(1'b0);
        step();
        step();
        chk("cl_pre", int'(locked_out), 1);
        clr = 1'b0;
        #1;
        chk_all_zero("clr");
        step();
        chk_all_zero("clr_hold");
        clr = 1'b1;
        strobe(1'b1);
        chk("cl_first", int'(unlock), 1);
        chk("cl_fc", int'(fail_cnt), 0);
        repeat (4) step();
        chk("cl_end", int'(unlock), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
